// File: rtl/mem_pkg.sv
// Shared opcodes, funct3 encodings, LSU state type and access helpers for the
// load/store path between the MEM stage and the word-addressed data memory.
package mem_pkg;

    localparam logic [6:0] LOAD_OP  = 7'b0000011;
    localparam logic [6:0] STORE_OP = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } lsu_state_t;

    // Undefined width, misalignment, or a word index past the end of memory.
    function automatic logic access_bad(
        input logic        is_store,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [31:0] depth_words
    );
        logic undefined;
        logic misaligned;
        logic out_of_range;
        if (is_store) begin
            undefined = (funct3 > F3_W);
        end else begin
            undefined = !((funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                          (funct3 == F3_BU) || (funct3 == F3_HU));
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        out_of_range = ({2'b00, addr[31:2]} >= depth_words);
        return undefined || misaligned || out_of_range;
    endfunction

    function automatic logic [3:0] lane_mask(
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        if (funct3 == F3_B) begin
            return 4'b0001 << addr_lo;
        end
        return 4'b0011 << {addr_lo[1], 1'b0};
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword lane of a memory word and sign- or
// zero-extends it according to the RV32I load funct3.
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] byte_lane;
    logic [31:0] half_lane;

    assign byte_lane = word_i >> {addr_lo_i, 3'b000};
    assign half_lane = word_i >> {addr_lo_i[1], 4'b0000};

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane[7:0]};
            F3_BU:   data_o = {24'h000000, byte_lane[7:0]};
            F3_H:    data_o = {{16{half_lane[15]}}, half_lane[15:0]};
            F3_HU:   data_o = {16'h0000, half_lane[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end for a word-addressed memory:
// single-cycle loads and SW, two-cycle read-modify-write for SB/SH.
module load_store_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [6:0]  reqOp,
    input  logic [2:0]  reqFunct3,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqStoreData,
    output logic        loadValid,
    output logic [31:0] loadData,
    output logic        fault,
    output logic [6:0]  memOp,
    output logic [31:0] memAddr,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData
);

    localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

    lsu_state_t  state_q, state_d;
    logic        load_valid_q;
    logic [31:0] load_data_q;
    logic        fault_q;

    logic [29:0] index_q;
    logic [3:0]  mask_q;
    logic [31:0] new_data_q;
    logic [31:0] old_data_q;

    logic        accept;
    logic        is_load;
    logic        is_store;
    logic        bad;
    logic        ok_load;
    logic        ok_store;
    logic        word_store;
    logic        sub_store;
    logic [31:0] extracted;
    logic [31:0] merge_mask;
    logic [31:0] store_lanes;

    assign reqReady   = (state_q == IDLE);
    assign accept     = reqValid && reqReady;
    assign is_load    = accept && (reqOp == LOAD_OP);
    assign is_store   = accept && (reqOp == STORE_OP);
    assign bad        = (is_load || is_store) &&
                        access_bad(is_store, reqFunct3, reqAddr, DEPTH);
    assign ok_load    = is_load && !bad;
    assign ok_store   = is_store && !bad;
    assign word_store = ok_store && (reqFunct3 == F3_W);
    assign sub_store  = ok_store && (reqFunct3 != F3_W);

    assign merge_mask  = expand_mask(mask_q);
    assign store_lanes = (reqFunct3 == F3_B) ? {4{reqStoreData[7:0]}}
                                             : {2{reqStoreData[15:0]}};

    load_extract u_load_extract (
        .word_i    (memReadData),
        .addr_lo_i (reqAddr[1:0]),
        .funct3_i  (reqFunct3),
        .data_o    (extracted)
    );

    // Memory-facing outputs are forced quiet during reset so an interrupted
    // MERGE never reaches the memory.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        memOp        = 7'd0;
        memAddr      = 32'd0;
        memWriteData = 32'd0;
        state_d      = state_q;
        if (state_q == MERGE) begin
            state_d = IDLE;
            if (!reset) begin
                memOp        = STORE_OP;
                memAddr      = {2'b00, index_q};
                memWriteData = (old_data_q & ~merge_mask) | (new_data_q & merge_mask);
            end
        end else begin
            if (sub_store) begin
                state_d = MERGE;
            end
            if (!reset && (ok_load || ok_store)) begin
                memAddr = {2'b00, reqAddr[31:2]};
            end
            if (!reset && word_store) begin
                memOp        = STORE_OP;
                memWriteData = reqStoreData;
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            load_valid_q <= 1'b0;
            load_data_q  <= 32'd0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_valid_q <= ok_load;
            fault_q      <= bad;
            if (ok_load) begin
                load_data_q <= extracted;
            end
        end
    end

    // NOTE: the merge datapath is not reset; it is only consumed in MERGE,
    // which is always entered through a cycle that loads all of it.
    always_ff @(posedge clock) begin
        if (sub_store && !reset) begin
            index_q    <= reqAddr[31:2];
            mask_q     <= lane_mask(reqFunct3, reqAddr[1:0]);
            new_data_q <= store_lanes;
            old_data_q <= memReadData;
        end
    end

    assign loadValid = load_valid_q;
    assign loadData  = load_data_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// word-addressed memory (combinational read, write on rising edge).
module tb_load_store_unit;
    import mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [6:0]  reqOp;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddr;
    logic [31:0] reqStoreData;
    logic        loadValid;
    logic [31:0] loadData;
    logic        fault;
    logic [6:0]  memOp;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    logic [31:0] mem [1024];

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.DEPTH_WORDS(1024)) dut (
        .clock        (clock),
        .reset        (reset),
        .reqValid     (reqValid),
        .reqReady     (reqReady),
        .reqOp        (reqOp),
        .reqFunct3    (reqFunct3),
        .reqAddr      (reqAddr),
        .reqStoreData (reqStoreData),
        .loadValid    (loadValid),
        .loadData     (loadData),
        .fault        (fault),
        .memOp        (memOp),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .memReadData  (memReadData)
    );

    initial forever #5 clock = ~clock;

    assign memReadData = mem[memAddr[9:0]];

    always @(posedge clock) begin
        if (memOp == STORE_OP) begin
            mem[memAddr[9:0]] <= memWriteData;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data);
        reqValid     = 1'b1;
        reqOp        = op;
        reqFunct3    = f3;
        reqAddr      = addr;
        reqStoreData = data;
    endtask

    task automatic idle();
        reqValid     = 1'b0;
        reqOp        = 7'd0;
        reqFunct3    = 3'd0;
        reqAddr      = 32'd0;
        reqStoreData = 32'd0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"},  {31'd0, reqReady},  32'd1);
        check({tag, "_lvalid"}, {31'd0, loadValid}, 32'd0);
        check({tag, "_ldata"},  loadData,           32'd0);
        check({tag, "_fault"},  {31'd0, fault},     32'd0);
        check({tag, "_memop"},  {25'd0, memOp},     32'd0);
        check({tag, "_maddr"},  memAddr,            32'd0);
        check({tag, "_wdata"},  memWriteData,       32'd0);
    endtask

    task automatic fault_case(input string tag, input logic [6:0] op,
                              input logic [2:0] f3, input logic [31:0] addr);
        drive(op, f3, addr, 32'hA5A5A5A5);
        #1 check({tag, "_memop_accept"}, {25'd0, memOp}, 32'd0);
        tick();
        idle();
        #1;
        check({tag, "_fault"},  {31'd0, fault},     32'd1);
        check({tag, "_lvalid"}, {31'd0, loadValid}, 32'd0);
        check({tag, "_memop"},  {25'd0, memOp},     32'd0);
        check({tag, "_ready"},  {31'd0, reqReady},  32'd1);
        tick();
        check({tag, "_fault_once"}, {31'd0, fault}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[8] = 32'hCAFEF00D;
        idle();
        reset = 1'b1;
        tick();
        tick();
        #1 check_quiet("reset");
        @(negedge clock);
        reset = 1'b0;

        // SW commits in the acceptance cycle, LW returns it one cycle later
        drive(STORE_OP, F3_W, 32'h10, 32'hDEADBEEF);
        #1;
        check("sw_memop",  {25'd0, memOp}, {25'd0, STORE_OP});
        check("sw_maddr",  memAddr,        32'd4);
        check("sw_wdata",  memWriteData,   32'hDEADBEEF);
        tick();
        drive(LOAD_OP, F3_W, 32'h10, 32'd0);
        #1;
        check("lw_maddr", memAddr,        32'd4);
        check("lw_memop", {25'd0, memOp}, 32'd0);
        check("lw_no_early_valid", {31'd0, loadValid}, 32'd0);
        tick();
        check("lw_valid", {31'd0, loadValid}, 32'd1);
        check("lw_data",  loadData,           32'hDEADBEEF);

        drive(LOAD_OP, F3_B, 32'h13, 32'd0);
        tick();
        check("lb_valid", {31'd0, loadValid}, 32'd1);
        check("lb_data",  loadData,           32'hFFFFFFDE);
        drive(LOAD_OP, F3_BU, 32'h13, 32'd0);
        tick();
        check("lbu_data", loadData, 32'h000000DE);
        drive(LOAD_OP, F3_H, 32'h10, 32'd0);
        tick();
        check("lh_data", loadData, 32'hFFFFBEEF);
        drive(LOAD_OP, F3_HU, 32'h12, 32'd0);
        tick();
        check("lhu_data",  loadData,       32'h0000DEAD);
        check("lhu_fault", {31'd0, fault}, 32'd0);

        // SB then SH read-modify-write on word 4
        drive(STORE_OP, F3_B, 32'h11, 32'h00000055);
        #1 check("sb_idle_memop", {25'd0, memOp}, 32'd0);
        tick();
        idle();
        #1;
        check("sb_merge_ready", {31'd0, reqReady}, 32'd0);
        check("sb_merge_memop", {25'd0, memOp},    {25'd0, STORE_OP});
        check("sb_merge_maddr", memAddr,           32'd4);
        check("sb_merge_wdata", memWriteData,      32'hDEAD55EF);
        check("sb_no_lvalid",   {31'd0, loadValid}, 32'd0);
        tick();
        check("sb_ready_back", {31'd0, reqReady}, 32'd1);
        check("sb_memop_once", {25'd0, memOp},    32'd0);
        drive(STORE_OP, F3_H, 32'h12, 32'h00001234);
        tick();
        idle();
        #1 check("sh_merge_wdata", memWriteData, 32'h123455EF);
        tick();
        check("sh_mem_word", mem[4], 32'h123455EF);

        // Misaligned and out-of-range accesses
        fault_case("lw_misaligned", LOAD_OP,  F3_W, 32'h11);
        fault_case("sh_misaligned", STORE_OP, F3_H, 32'h13);
        fault_case("sw_range",      STORE_OP, F3_W, 32'h1000);
        check("fault_mem4_kept", mem[4], 32'h123455EF);
        check("fault_mem0_kept", mem[0], 32'd0);

        // Reset during MERGE of SB 0x20 discards the write
        drive(STORE_OP, F3_B, 32'h20, 32'h000000AA);
        tick();
        idle();
        reset = 1'b1;
        #1 check("rst_merge_memop", {25'd0, memOp}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_merge_word", mem[8], 32'hCAFEF00D);
        check_quiet("post_reset");

        // SW, SB, LW to word 12 back to back
        drive(STORE_OP, F3_W, 32'h30, 32'h11223344);
        #1 check("stream_sw_ready", {31'd0, reqReady}, 32'd1);
        tick();
        drive(STORE_OP, F3_B, 32'h31, 32'h000000AB);
        #1 check("stream_sb_ready", {31'd0, reqReady}, 32'd1);
        tick();
        drive(LOAD_OP, F3_W, 32'h30, 32'd0);
        #1;
        check("stream_merge_ready", {31'd0, reqReady}, 32'd0);
        check("stream_merge_wdata", memWriteData,      32'h1122AB44);
        tick();
        #1;
        check("stream_lw_ready", {31'd0, reqReady}, 32'd1);
        check("stream_lw_maddr", memAddr,           32'd12);
        check("stream_lw_quiet", {31'd0, loadValid}, 32'd0);
        tick();
        idle();
        check("stream_lw_valid", {31'd0, loadValid}, 32'd1);
        check("stream_lw_data",  loadData,           32'h1122AB44);
        tick();
        check("stream_lvalid_once", {31'd0, loadValid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Sits between the MEM pipeline stage and the word-addressed data memory.
- Accepts byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Converts byte addresses to word indices and extracts and sign/zero-extends load data.
- Performs sub-word stores as a two-cycle read-modify-write.
- Flags misaligned or out-of-range accesses instead of issuing them to memory.

## Interface
Parameters:
- DEPTH_WORDS, 1024: data memory depth in 32-bit words; must be a power of two.

Ports:
- clock  in  1  sole clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- reqValid  in  1  request present from MEM stage.
- reqReady  out  1  unit can accept a request this cycle.
- reqOp  in  7  opcode; LOAD_OP or STORE_OP, anything else ignored.
- reqFunct3  in  3  RV32I width/sign field.
- reqAddr  in  32  byte address.
- reqStoreData  in  32  store source register value.
- loadValid  out  1  one-cycle pulse, loadData valid.
- loadData  out  32  extended load result.
- fault  out  1  one-cycle pulse: misaligned or out-of-range access dropped.
- memOp  out  7  STORE_OP when writing memory, 7'd0 otherwise.
- memAddr  out  32  word index, equal to reqAddr[31:2] or the latched index.
- memWriteData  out  32  word to write.
- memReadData  in  32  combinational read of word at memAddr.

## Operation
- Handshake: a request is accepted when reqValid && reqReady; requests with any other opcode are accepted and discarded silently.
- reqReady = 1 in IDLE, 0 in MERGE.

Access checks are applied to every accepted LOAD/STORE:
- Halfword with addr[0]=1 is misaligned.
- Word with addr[1:0]≠0 is misaligned.
- Any addr[31:2] ≥ DEPTH_WORDS is out of range.
- Undefined funct3 (LOAD 3,6,7; STORE ≥3) faults.
- Fault behaviour: fault pulses the next cycle, no memory write, no loadValid.

Loads (IDLE, 1 cycle):
- memAddr = addr[31:2].
- Lane is selected by addr[1:0] for bytes and addr[1] for halves.
- LB/LH sign-extend; LBU/LHU zero-extend.
- The result is registered: loadValid=1 and loadData on the following cycle.

SW (IDLE, 1 cycle):
- memOp = STORE_OP, memAddr = addr[31:2], memWriteData = reqStoreData.
- Committed in the acceptance cycle.

SB/SH use a two-state FSM:
- IDLE: latch word index, byte mask, shifted store data and memReadData into a merge register; go to MERGE. memOp = 0.
- MERGE: memOp = STORE_OP, memAddr = latched index, memWriteData = (old & ~mask) | (new & mask); return to IDLE.
- Byte mask per lane: SB uses 4'b0001 << addr[1:0]; SH uses 4'b0011 << {addr[1],1'b0}.

## Timing
- Reset values: state IDLE, reqReady 1, loadValid 0, loadData 0, fault 0, memOp 0, memAddr 0, memWriteData 0.
- Reset asserted in MERGE aborts the write: memOp is 0 in the reset cycle and the merge is discarded.
- Load latency is 1 cycle, acceptance to loadValid.
- SW: 1 cycle, throughput 1 per cycle.
- SB/SH: 2 cycles, next acceptance possible in the cycle after MERGE.
- Back-to-back load after store to the same word observes the new data, because memory writes on the MERGE/IDLE edge and reads combinationally.
- loadValid and fault are never asserted together.
- Both are 0 on any cycle not following an accepted LOAD or bad access.
- memOp is STORE_OP for exactly one cycle per committed store.

## Structure
- Shared package mem_pkg holds:
  - LOAD_OP (7'b0000011) and STORE_OP (7'b0100011);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum lsu_state_t {IDLE, MERGE}.
- One natural sub-module: load_extract (combinational lane select plus sign/zero extension from word, addr[1:0], funct3).

## Test plan
- SW addr 0x10 data 0xDEADBEEF: memOp=STORE_OP, memAddr=4, memWriteData=0xDEADBEEF same cycle. Then LW 0x10 gives loadData 0xDEADBEEF, loadValid one cycle later.
- With word 4 = 0xDEADBEEF:
  - LB 0x13 gives 0xFFFFFFDE.
  - LBU 0x13 gives 0x000000DE.
  - LH 0x10 gives 0xFFFFBEEF.
  - LHU 0x12 gives 0x0000DEAD.
- SB 0x11 data 0x00000055 on word 0xDEADBEEF: reqReady=0 for one cycle, then memWriteData=0xDEAD55EF. SH 0x12 data 0x1234 then yields 0x123455EF.
- Misaligned and out-of-range accesses each give a single fault pulse, no memOp, and memory unchanged:
  - LW 0x11.
  - SH 0x13.
  - SW 0x1000 with DEPTH_WORDS=1024.
- Reset asserted during MERGE of SB 0x20: no write occurs, the word is unchanged, and after reset reqReady=1 and all outputs are 0.
- Stream of SW, SB, LW to the same word on consecutive cycles: reqReady drops only during MERGE, and LW returns the merged value.
